// File: rtl/tile_pkg.sv
// Shared tile-fetch definitions: pattern layout, attribute bit positions, fetch FSM states.
package tile_pkg;
    localparam int TILE_BYTES   = 32;
    localparam int ROW_BYTES    = 4;
    localparam int ATTR_FLIPH   = 7;
    localparam int ATTR_FLIPV   = 6;
    localparam int ATTR_PAL_MSB = 1;
    localparam int ATTR_PAL_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAP_IDX,
        ST_MAP_ATTR,
        ST_PIX0,
        ST_PIX1,
        ST_PIX2,
        ST_PIX3,
        ST_WAIT
    } fetch_state_t;
endpackage

// File: rtl/tile_pixel_shifter.sv
// Eight-pixel output buffer: loads one 4bpp pattern row (optionally mirrored, leading pixels skipped,
// length limited) and presents one {palette,color} pixel per cycle, advancing on valid && ready.
module tile_pixel_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] pattern,
    input  logic [1:0]  palette,
    input  logic        flip_h,
    input  logic [2:0]  skip,
    input  logic [3:0]  count,
    input  logic        ready,
    output logic [5:0]  pixel,
    output logic        valid,
    output logic        empty,
    output logic        last
);
    logic [31:0] pix_q;
    logic [31:0] ordered;
    logic [1:0]  pal_q;
    logic [3:0]  cnt_q;

    // Pixel 0 lives in the top nibble; mirroring reverses nibble order.
    always_comb begin
        ordered = '0;
        for (int i = 0; i < 8; i++) begin
            ordered[31-4*i -: 4] = flip_h ? pattern[4*i+3 -: 4] : pattern[31-4*i -: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q <= '0;
            pal_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            pix_q <= ordered << {skip, 2'b00};
            pal_q <= palette;
            cnt_q <= count;
        end else if (valid && ready) begin
            pix_q <= {pix_q[27:0], 4'h0};
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign valid = (cnt_q != 4'd0);
    assign empty = !valid;
    assign last  = (cnt_q == 4'd1);
    assign pixel = valid ? {pal_q, pix_q[31:28]} : 6'd0;
endmodule

// File: rtl/tile_row_fetcher.sv
// Walks one scanline of the tile map and streams {palette,color} pixels; first pixel 7 cycles after start.
// Fetch stalls in WAIT while the output buffer is full. Horizontal scroll: TILE_ROW_FETCHER_SCROLL_EN.
module tile_row_fetcher
    import tile_pkg::*;
#(
    parameter int Bits     = 16,
    parameter int MapBase  = 0,
    parameter int TileBase = 8192,
    parameter int MapWidth = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      lineY,
`ifdef TILE_ROW_FETCHER_SCROLL_EN
    input  logic [7:0]      scrollX,
`endif
    output logic [Bits-1:0] memAddr,
    input  logic [7:0]      memData,
    output logic            memRead,
    output logic [5:0]      pixel,
    output logic            pixelValid,
    input  logic            pixelReady,
    output logic            busy,
    output logic            done
);
    localparam int CW = (MapWidth > 1) ? $clog2(MapWidth) : 1;
    localparam int TW = $clog2(MapWidth + 2);

    fetch_state_t    state, state_next;
    logic [7:0]      line_q, idx_q;
    logic            flip_h_q, flip_v_q;
    logic [1:0]      pal_q;
    logic [31:0]     stage_q;
    logic [CW-1:0]   col_q, col_start;
    logic [TW-1:0]   tiles_q, tiles_total;
    logic [2:0]      skip, row;
    logic [3:0]      count;
    logic            start_acc, final_acc, load, last_tile, sh_empty, sh_last;
    logic [Bits-1:0] map_addr, pix_addr;

    assign start_acc = (state == ST_IDLE) && !busy && start;
    assign final_acc = busy && (state == ST_IDLE) && sh_last && pixelValid && pixelReady;
    assign last_tile = ((tiles_q + TW'(1)) == tiles_total);

`ifdef TILE_ROW_FETCHER_SCROLL_EN
    logic [2:0] fine_q;
    logic       first_q;

    assign col_start   = CW'(int'(scrollX[7:3]) % MapWidth);
    assign tiles_total = TW'(MapWidth) + TW'(fine_q != 3'd0);
    assign skip        = first_q ? fine_q : 3'd0;
    // The partial tile at the end supplies exactly the pixels dropped from the first one.
    assign count       = first_q ? (4'd8 - {1'b0, fine_q}) :
                         (last_tile && fine_q != 3'd0) ? {1'b0, fine_q} : 4'd8;

    always_ff @(posedge clk) begin
        if (reset) begin
            fine_q  <= '0;
            first_q <= 1'b0;
        end else if (start_acc) begin
            fine_q  <= scrollX[2:0];
            first_q <= 1'b1;
        end else if (load) begin
            first_q <= 1'b0;
        end
    end
`else
    assign col_start   = '0;
    assign tiles_total = TW'(MapWidth);
    assign skip        = 3'd0;
    assign count       = 4'd8;
`endif

    assign row      = flip_v_q ? ~line_q[2:0] : line_q[2:0];
    assign map_addr = Bits'(MapBase) + ((Bits'(line_q[7:3]) * Bits'(MapWidth) + Bits'(col_q)) << 1);
    assign pix_addr = Bits'(TileBase) + Bits'(idx_q) * Bits'(TILE_BYTES) + Bits'(row) * Bits'(ROW_BYTES);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        memAddr    = '0;
        memRead    = 1'b0;
        load       = 1'b0;
        case (state)
            ST_IDLE:     if (start_acc) state_next = ST_MAP_IDX;
            ST_MAP_IDX:  begin memRead = 1'b1; memAddr = map_addr;              state_next = ST_MAP_ATTR; end
            ST_MAP_ATTR: begin memRead = 1'b1; memAddr = map_addr + Bits'(1);   state_next = ST_PIX0;     end
            ST_PIX0:     begin memRead = 1'b1; memAddr = pix_addr;              state_next = ST_PIX1;     end
            ST_PIX1:     begin memRead = 1'b1; memAddr = pix_addr + Bits'(1);   state_next = ST_PIX2;     end
            ST_PIX2:     begin memRead = 1'b1; memAddr = pix_addr + Bits'(2);   state_next = ST_PIX3;     end
            ST_PIX3:     begin memRead = 1'b1; memAddr = pix_addr + Bits'(3);   state_next = ST_WAIT;     end
            ST_WAIT: begin
                // Hand over when the buffer frees up this edge, keeping the stream gap-free.
                if (sh_empty || (sh_last && pixelValid && pixelReady)) begin
                    load       = 1'b1;
                    state_next = last_tile ? ST_IDLE : ST_MAP_IDX;
                end
            end
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q   <= '0;
            idx_q    <= '0;
            flip_h_q <= 1'b0;
            flip_v_q <= 1'b0;
            pal_q    <= '0;
            stage_q  <= '0;
            col_q    <= '0;
            tiles_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= final_acc;
            if (final_acc)      busy <= 1'b0;
            else if (start_acc) busy <= 1'b1;
            if (start_acc) begin
                line_q  <= lineY;
                col_q   <= col_start;
                tiles_q <= '0;
            end
            case (state)
                ST_MAP_IDX:  idx_q <= memData;
                ST_MAP_ATTR: begin
                    flip_h_q <= memData[ATTR_FLIPH];
                    flip_v_q <= memData[ATTR_FLIPV];
                    pal_q    <= memData[ATTR_PAL_MSB:ATTR_PAL_LSB];
                end
                ST_PIX0:     stage_q[31:24] <= memData;
                ST_PIX1:     stage_q[23:16] <= memData;
                ST_PIX2:     stage_q[15:8]  <= memData;
                ST_PIX3:     stage_q[7:0]   <= memData;
                default:     ;
            endcase
            if (load) begin
                col_q   <= (col_q == CW'(MapWidth - 1)) ? '0 : col_q + CW'(1);
                tiles_q <= tiles_q + TW'(1);
            end
        end
    end

    tile_pixel_shifter u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .pattern (stage_q),
        .palette (pal_q),
        .flip_h  (flip_h_q),
        .skip    (skip),
        .count   (count),
        .ready   (pixelReady),
        .pixel   (pixel),
        .valid   (pixelValid),
        .empty   (sh_empty),
        .last    (sh_last)
    );
endmodule

// File: tb/tb_tile_row_fetcher.sv
// Directed bench for tile_row_fetcher with a combinational-read RAM model.
module tb_tile_row_fetcher;
    logic        clk, reset, start, pixelReady;
    logic [7:0]  lineY, memData;
    logic [15:0] memAddr;
    logic        memRead, pixelValid, busy, done;
    logic [5:0]  pixel;
`ifdef TILE_ROW_FETCHER_SCROLL_EN
    logic [7:0]  scrollX;
`endif

    logic [7:0] ram [0:65535];
    assign memData = ram[memAddr];

    tile_row_fetcher dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .lineY      (lineY),
`ifdef TILE_ROW_FETCHER_SCROLL_EN
        .scrollX    (scrollX),
`endif
        .memAddr    (memAddr),
        .memData    (memData),
        .memRead    (memRead),
        .pixel      (pixel),
        .pixelValid (pixelValid),
        .pixelReady (pixelReady),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    logic [5:0]  got [$];
    int          first_valid, dones, reads, gaps, stable_bad, busy_bad;
    logic [15:0] addr_log [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] model(input logic [7:0] y, input logic [7:0] sx, input int k);
        int p, c, ea, r, x;
        logic [7:0] idx, at, b;
        p   = k + int'(sx[2:0]);
        c   = (int'(sx[7:3]) + p / 8) % 32;
        ea  = (int'(y[7:3]) * 32 + c) * 2;
        idx = ram[ea];
        at  = ram[ea + 1];
        r   = at[6] ? 7 - int'(y[2:0]) : int'(y[2:0]);
        x   = p % 8;
        if (at[7]) x = 7 - x;
        b   = ram[8192 + int'(idx) * 32 + r * 4 + x / 2];
        return {at[1:0], (x % 2 == 1) ? b[3:0] : b[7:4]};
    endfunction

    // mode 0: ready held high; mode 1: ready toggles and a stray start is pulsed mid-line.
    task automatic run_line(input logic [7:0] y, input logic [7:0] sx, input int mode, input int abort_at);
        int n, post;
        logic prev_stall;
        logic [5:0] prev_pix;
        got.delete();
        first_valid = -1; dones = 0; reads = 0; gaps = 0; stable_bad = 0; busy_bad = 0;
        prev_stall = 1'b0; prev_pix = '0; post = -1;
        @(negedge clk);
        start = 1'b1; lineY = y;
`ifdef TILE_ROW_FETCHER_SCROLL_EN
        scrollX = sx;
`endif
        @(negedge clk);
        start = 1'b0; lineY = ~y;
`ifdef TILE_ROW_FETCHER_SCROLL_EN
        scrollX = ~sx;
`endif
        n = 0;
        while (n < 4000) begin
            if (n < 3) addr_log[n] = memAddr;
            if (pixelValid && first_valid < 0) first_valid = n;
            if (memRead) reads++;
            if (done) begin
                dones++;
                if (busy) busy_bad++;
                if (post < 0) post = n;
            end else if (dones == 0 && !busy) busy_bad++;
            if (prev_stall && (!pixelValid || pixel !== prev_pix)) stable_bad++;
            if (first_valid >= 0 && got.size() < 256 && !pixelValid) gaps++;
            pixelReady = (mode == 0) ? 1'b1 : (n % 2 == 0);
            start = (mode == 1 && n == 50);
            if (pixelValid && pixelReady) got.push_back(pixel);
            prev_stall = pixelValid && !pixelReady;
            prev_pix   = pixel;
            if (abort_at > 0 && got.size() == abort_at) break;
            if (post >= 0 && n >= post + 3) break;
            n++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_model(input string tag, input logic [7:0] y, input logic [7:0] sx);
        int mm = 0;
        for (int k = 0; k < got.size(); k++)
            if (got[k] !== model(y, sx, k)) mm++;
        check(tag, mm, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_addr"},  memAddr, 0);
        check({tag, "_read"},  memRead, 0);
        check({tag, "_pixel"}, pixel, 0);
        check({tag, "_valid"}, pixelValid, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
    endtask

    logic [5:0] exp_b [8] = '{6'h00, 6'h0e, 6'h08, 6'h00, 6'h08, 6'h08, 6'h00, 6'h00};
    logic [5:0] exp_c [8] = '{6'h10, 6'h10, 6'h18, 6'h18, 6'h10, 6'h18, 6'h1e, 6'h10};
    logic [5:0] exp_e [8] = '{6'h0a, 6'h01, 6'h0b, 6'h02, 6'h0c, 6'h03, 6'h0d, 6'h04};

    initial begin
        reset = 1'b1; start = 1'b0; lineY = '0; pixelReady = 1'b0;
`ifdef TILE_ROW_FETCHER_SCROLL_EN
        scrollX = '0;
`endif
        for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
        ram[8192] = 8'h0e; ram[8193] = 8'h80; ram[8194] = 8'h88; ram[8195] = 8'h00;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        // Plain line, every map entry is tile 0 with attribute 0.
        run_line(8'd0, 8'd0, 0, 0);
        for (int i = 0; i < 8; i++) check("b_first_tile", got[i], exp_b[i]);
        check("b_latency", first_valid, 7);
        check("b_map_idx_addr", addr_log[0], 16'd0);
        check("b_map_attr_addr", addr_log[1], 16'd1);
        check("b_pix0_addr", addr_log[2], 16'd8192);
        check("b_count", got.size(), 256);
        check("b_done_pulses", dones, 1);
        check("b_busy", busy_bad, 0);
        check("b_reads", reads, 192);
        check("b_gaps", gaps, 0);
        check_model("b_model", 8'd0, 8'd0);

        // flipH + palette 1 on column 0; column 5 uses tile 2 with every attribute bit set.
        ram[1] = 8'h81; ram[10] = 8'h02; ram[11] = 8'hff;
        ram[8284] = 8'h12; ram[8285] = 8'h34; ram[8286] = 8'h56; ram[8287] = 8'h78;
        run_line(8'd0, 8'd0, 1, 0);
        for (int i = 0; i < 8; i++) check("c_first_tile", got[i], exp_c[i]);
        for (int i = 0; i < 8; i++) check("c_col5", got[40+i], 6'h38 - 6'(i));
        check("c_count", got.size(), 256);
        check("c_done_pulses", dones, 1);
        check("c_stable", stable_bad, 0);
        check("c_busy", busy_bad, 0);
        check("c_reads", reads, 192);
        check_model("c_model", 8'd0, 8'd0);

        // flipV + palette 2 selects the all-zero row 7; line aborted by reset at pixel 100.
        ram[1] = 8'h42;
        run_line(8'd0, 8'd0, 0, 100);
        for (int i = 0; i < 8; i++) check("d_first_tile", got[i], 6'h20);
        check("d_pix0_addr", addr_log[2], 16'd8220);
        check("d_abort_count", got.size(), 100);
        reset = 1'b1;
        @(negedge clk);
        check_idle("d_reset");
        reset = 1'b0;

        // Fresh line on map row 1, pattern row 1.
        ram[8196] = 8'ha1; ram[8197] = 8'hb2; ram[8198] = 8'hc3; ram[8199] = 8'hd4;
        run_line(8'd9, 8'd0, 0, 0);
        for (int i = 0; i < 8; i++) check("e_first_tile", got[i], exp_e[i]);
        check("e_map_idx_addr", addr_log[0], 16'd64);
        check("e_count", got.size(), 256);
        check("e_done_pulses", dones, 1);
        check("e_gaps", gaps, 0);
        check_model("e_model", 8'd9, 8'd0);

`ifdef TILE_ROW_FETCHER_SCROLL_EN
        // Start at column 1 pixel 3; the line wraps from column 31 to column 0.
        ram[2] = 8'h02; ram[3] = 8'h01;
        ram[8256] = 8'h9a; ram[8257] = 8'hbc; ram[8258] = 8'hde; ram[8259] = 8'hf1;
        run_line(8'd0, 8'h0b, 0, 0);
        check("f_first_pixel", got[0], 6'h1c);
        check("f_wrap_col0", got[245], 6'h20);
        check("f_count", got.size(), 256);
        check("f_done_pulses", dones, 1);
        check("f_reads", reads, 198);
        check("f_gaps", gaps, 0);
        check_model("f_model", 8'd0, 8'h0b);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
